// File: rtl/cnn_feeder_pkg.sv
// Shared types and width helpers for the IFM pair feeder.
package cnn_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    localparam int STALL_CNT_W = 16;

    // Width of a counter that must hold 0..n_pairs inclusive (saturated value).
    function automatic int pair_cnt_width(input int n_pairs);
        return (n_pairs < 2) ? 1 : $clog2(n_pairs + 1);
    endfunction

    // Width of a row/column position that must hold 0..ifm_size inclusive.
    function automatic int pos_width(input int ifm_size);
        return $clog2(ifm_size) + 1;
    endfunction

endpackage

// File: rtl/feeder_skid_buffer.sv
// One-entry skid plus output register for the pixel-pair stream.
// RAM returns land in the output register when it is empty or shifting,
// otherwise in the skid; the skid always refills the output register first.
module feeder_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ret_valid,
    input  logic [WIDTH-1:0] ret_data,
    input  logic             feed_stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             skid_full,
    output logic             shift
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    assign shift     = out_valid & ~feed_stall;
    assign skid_full = skid_valid;

    // Output register / skid update with skid-first ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || shift) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= ret_valid;
                if (ret_valid) begin
                    skid_data <= ret_data;
                end
            end else if (ret_valid) begin
                out_valid <= 1'b1;
                out_data  <= ret_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (ret_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= ret_data;
        end
    end

endmodule

// File: rtl/ifm_pair_feeder.sv
// Streams one IFM channel from a dual-port RAM into the dual-input window
// shift register, two pixels per shift, and flags complete KxK windows.
// Optional build macro: FEEDER_STALL_CNT_EN adds the stall_count output.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing pair reads until the last one is issued
// DRAIN | waiting for the in-flight pairs to shift out
// DONE  | one-cycle done pulse
module ifm_pair_feeder
    import cnn_feeder_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int IFM_SIZE         = 32,
    parameter int KERNAL_SIZE      = 5,
    parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int NUMBER_OF_PAIRS  = IFM_SIZE * IFM_SIZE / 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDRESS_SIZE_IFM-1:0] base_address,
    input  logic                        feed_stall,
    output logic                        ifm_read_enable,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_1,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_2,
    input  logic [DATA_WIDTH-1:0]       ifm_data_1,
    input  logic [DATA_WIDTH-1:0]       ifm_data_2,
    output logic                        fifo_enable,
    output logic [DATA_WIDTH-1:0]       fifo_data_in,
    output logic [DATA_WIDTH-1:0]       fifo_data_in_2,
    output logic                        window_valid_1,
    output logic                        window_valid_2,
    output logic                        busy,
    output logic                        done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]      stall_count
`endif
);

    localparam int PAIR_W = pair_cnt_width(NUMBER_OF_PAIRS);
    localparam int POS_W  = pos_width(IFM_SIZE);

    feeder_state_t               state, state_nxt;
    logic [ADDRESS_SIZE_IFM-1:0] base_q;
    logic [PAIR_W-1:0]           rd_cnt;
    logic                        ret_valid;
    logic                        accept;
    logic                        last_read;
    logic                        out_valid;
    logic                        skid_full;
    logic                        shift;
    logic [2*DATA_WIDTH-1:0]     out_data;
    logic [POS_W-1:0]            col_a;
    logic [POS_W-1:0]            row;
    logic [POS_W-1:0]            col_b;
    logic [POS_W-1:0]            col_next;

    assign accept    = (state == IDLE) && start;
    assign last_read = (rd_cnt == PAIR_W'(NUMBER_OF_PAIRS - 1));

    assign ifm_address_1 = base_q + ADDRESS_SIZE_IFM'({rd_cnt, 1'b0});
    assign ifm_address_2 = ifm_address_1 + ADDRESS_SIZE_IFM'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read strobe and status outputs.
    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        ifm_read_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy            = 1'b1;
                ifm_read_enable = ~feed_stall & ~skid_full;
                if (!feed_stall && !skid_full && last_read) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!out_valid && !skid_full && !ret_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Base latch, pair read counter and one-cycle RAM return marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q    <= '0;
            rd_cnt    <= '0;
            ret_valid <= 1'b0;
        end else begin
            ret_valid <= ifm_read_enable;
            if (accept) begin
                base_q <= base_address;
                rd_cnt <= '0;
            end else if (ifm_read_enable) begin
                rd_cnt <= rd_cnt + PAIR_W'(1);
            end
        end
    end

    feeder_skid_buffer #(
        .WIDTH(2 * DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .ret_valid (ret_valid),
        .ret_data  ({ifm_data_2, ifm_data_1}),
        .feed_stall(feed_stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .skid_full (skid_full),
        .shift     (shift)
    );

    assign fifo_enable    = shift;
    assign fifo_data_in   = out_data[DATA_WIDTH-1:0];
    assign fifo_data_in_2 = out_data[2*DATA_WIDTH-1:DATA_WIDTH];

    assign col_b    = col_a + POS_W'(1);
    assign col_next = col_a + POS_W'(2);

    // Raster position of the next shifted pair and registered window flags.
    // The column wraps at each row start so windows never span rows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_a          <= '0;
            row            <= '0;
            window_valid_1 <= 1'b0;
            window_valid_2 <= 1'b0;
        end else begin
            window_valid_1 <= 1'b0;
            window_valid_2 <= 1'b0;
            if (accept) begin
                col_a <= '0;
                row   <= '0;
            end else if (shift) begin
                window_valid_1 <= (row >= POS_W'(KERNAL_SIZE - 1)) &&
                                  (col_b >= POS_W'(KERNAL_SIZE - 1));
                window_valid_2 <= (row >= POS_W'(KERNAL_SIZE - 1)) &&
                                  (col_a >= POS_W'(KERNAL_SIZE - 1));
                if (col_next >= POS_W'(IFM_SIZE)) begin
                    col_a <= '0;
                    row   <= row + POS_W'(1);
                end else begin
                    col_a <= col_next;
                end
            end
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of cycles where a valid pair is held by a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (accept) begin
            stall_count <= '0;
        end else if (out_valid && feed_stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ifm_pair_feeder.sv
// Directed bench for ifm_pair_feeder: 8x8 IFM, 3x3 window, RAM pixel = address.
module tb_ifm_pair_feeder;

    localparam int DW  = 32;
    localparam int IFM = 8;
    localparam int K   = 3;
    localparam int AW  = 7;
    localparam int NP  = IFM * IFM / 2;
    localparam int LOG = 1024;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic          feed_stall;
    logic          ifm_read_enable;
    logic [AW-1:0] ifm_address_1;
    logic [AW-1:0] ifm_address_2;
    logic [DW-1:0] ifm_data_1;
    logic [DW-1:0] ifm_data_2;
    logic          fifo_enable;
    logic [DW-1:0] fifo_data_in;
    logic [DW-1:0] fifo_data_in_2;
    logic          window_valid_1;
    logic          window_valid_2;
    logic          busy;
    logic          done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    ifm_pair_feeder #(
        .DATA_WIDTH      (DW),
        .IFM_SIZE        (IFM),
        .KERNAL_SIZE     (K),
        .ADDRESS_SIZE_IFM(AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_address   (base_address),
        .feed_stall     (feed_stall),
        .ifm_read_enable(ifm_read_enable),
        .ifm_address_1  (ifm_address_1),
        .ifm_address_2  (ifm_address_2),
        .ifm_data_1     (ifm_data_1),
        .ifm_data_2     (ifm_data_2),
        .fifo_enable    (fifo_enable),
        .fifo_data_in   (fifo_data_in),
        .fifo_data_in_2 (fifo_data_in_2),
        .window_valid_1 (window_valid_1),
        .window_valid_2 (window_valid_2),
        .busy           (busy),
        .done           (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous dual-port RAM model plus address legality tracking.
    int exp_base = 0;
    int n_reads  = 0;
    int addr_bad = 0;
    always @(posedge clk) begin
        if (ifm_read_enable) begin
            ifm_data_1 <= DW'(ifm_address_1);
            ifm_data_2 <= DW'(ifm_address_2);
            n_reads = n_reads + 1;
            if (int'(ifm_address_1) < exp_base || int'(ifm_address_1) > exp_base + IFM * IFM - 2 ||
                int'(ifm_address_2) != int'(ifm_address_1) + 1)
                addr_bad = addr_bad + 1;
        end
    end

    // Shift / flag / done logger, sampled on the falling edge.
    logic [DW-1:0] a_log [LOG];
    logic [DW-1:0] b_log [LOG];
    logic          f1_log[LOG];
    logic          f2_log[LOG];
    int n_shift = 0;
    int n_flag  = 0;
    int n_spur  = 0;
    int n_done  = 0;
    logic prev_shift = 1'b0;
    always @(negedge clk) begin
        if (prev_shift) begin
            if (n_flag < LOG) begin
                f1_log[n_flag] = window_valid_1;
                f2_log[n_flag] = window_valid_2;
            end
            n_flag = n_flag + 1;
        end else if (window_valid_1 || window_valid_2) begin
            n_spur = n_spur + 1;
        end
        if (fifo_enable) begin
            if (n_shift < LOG) begin
                a_log[n_shift] = fifo_data_in;
                b_log[n_shift] = fifo_data_in_2;
            end
            n_shift = n_shift + 1;
        end
        prev_shift = fifo_enable;
        if (done) n_done = n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one logged pass against the raster-order reference.
    task automatic check_pass(input string tag, input int base, input int s0, input int f0);
        int row, ca;
        logic e1, e2;
        chk({tag, "_shift_count"}, 64'(n_shift - s0), 64'(NP));
        chk({tag, "_flag_count"},  64'(n_flag - f0),  64'(NP));
        for (int k = 0; k < NP; k++) begin
            row = (2 * k) / IFM;
            ca  = (2 * k) % IFM;
            e1  = (row >= K - 1) && (ca + 1 >= K - 1);
            e2  = (row >= K - 1) && (ca >= K - 1);
            if (s0 + k < LOG) begin
                chk($sformatf("%s_pix_a[%0d]", tag, k), 64'(a_log[s0 + k]), 64'(base + 2 * k));
                chk($sformatf("%s_pix_b[%0d]", tag, k), 64'(b_log[s0 + k]), 64'(base + 2 * k + 1));
            end
            if (f0 + k < LOG) begin
                chk($sformatf("%s_wv1[%0d]", tag, k), 64'(f1_log[f0 + k]), 64'(e1));
                chk($sformatf("%s_wv2[%0d]", tag, k), 64'(f2_log[f0 + k]), 64'(e2));
            end
        end
    endtask

    // mode 0: no stall, 1: stall every other cycle, 2: 5-cycle stall after
    // two reads, 3: no stall with a start pulse (base 64) while busy.
    // Entered and left just after a rising edge.
    task automatic run_pass(input string tag, input int base, input int mode);
        int s0, f0, d0, r0, sp0, i;
        s0  = n_shift;
        f0  = n_flag;
        d0  = n_done;
        r0  = n_reads;
        sp0 = n_spur;
        exp_base = base;
        base_address = AW'(base);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(busy), 64'(1));
        i = 0;
        while (i < 600 && n_done == d0) begin
            case (mode)
                1: feed_stall = i[0];
                2: feed_stall = (i >= 2 && i <= 6);
                default: feed_stall = 1'b0;
            endcase
            if (mode == 3 && i == 5) begin
                start = 1'b1;
                base_address = AW'(64);
            end
            if (mode == 3 && i == 6) start = 1'b0;
            @(negedge clk);
            if (mode == 2 && i >= 2 && i <= 6) begin
                chk($sformatf("%s_rd_low_stalled[%0d]", tag, i), 64'(ifm_read_enable), 64'(0));
                chk($sformatf("%s_no_shift_stalled[%0d]", tag, i), 64'(fifo_enable), 64'(0));
            end
            if (mode == 2 && i == 7) begin
                chk({tag, "_rd_low_skid_full"}, 64'(ifm_read_enable), 64'(0));
                chk({tag, "_shift_on_release"}, 64'(fifo_enable), 64'(1));
                chk({tag, "_first_pair_a"}, 64'(fifo_data_in), 64'(base));
            end
            if (mode == 2 && i == 8)
                chk({tag, "_rd_resumes"}, 64'(ifm_read_enable), 64'(1));
            @(posedge clk); #1;
            i = i + 1;
        end
        feed_stall = 1'b0;
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(n_done - d0), 64'(1));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_single_done"}, 64'(n_done - d0), 64'(1));
        chk({tag, "_busy_low"},    64'(busy), 64'(0));
        chk({tag, "_read_count"},  64'(n_reads - r0), 64'(NP));
        chk({tag, "_addr_range"},  64'(addr_bad), 64'(0));
        chk({tag, "_no_stray_flag"}, 64'(n_spur - sp0), 64'(0));
`ifdef FEEDER_STALL_CNT_EN
        if (mode == 2) chk({tag, "_stall_count"}, 64'(stall_count), 64'(5));
`endif
        check_pass(tag, base, s0, f0);
    endtask

    initial begin
        int d0;
        reset        = 1'b0;
        start        = 1'b0;
        feed_stall   = 1'b0;
        base_address = '0;
        #2;
        chk("rst_busy",     64'(busy), 64'(0));
        chk("rst_done",     64'(done), 64'(0));
        chk("rst_rd_en",    64'(ifm_read_enable), 64'(0));
        chk("rst_fifo_en",  64'(fifo_enable), 64'(0));
        chk("rst_addr1",    64'(ifm_address_1), 64'(0));
        chk("rst_data_in",  64'(fifo_data_in), 64'(0));
        chk("rst_data_in2", 64'(fifo_data_in_2), 64'(0));
        chk("rst_wv",       64'({window_valid_1, window_valid_2}), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        feed_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_stall_no_effect", 64'({busy, ifm_read_enable, fifo_enable}), 64'(0));
        feed_stall = 1'b0;

        run_pass("basic", 0, 0);
        run_pass("alt_stall", 0, 1);
        run_pass("skid", 0, 2);
        run_pass("base64", 64, 0);

        // Asynchronous reset in the middle of RUN.
        d0 = n_done;
        exp_base = 0;
        base_address = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy",    64'(busy), 64'(0));
        chk("midrst_rd_en",   64'(ifm_read_enable), 64'(0));
        chk("midrst_fifo_en", 64'(fifo_enable), 64'(0));
        chk("midrst_addr",    64'({ifm_address_1, ifm_address_2}), 64'({7'd0, 7'd1}));
        chk("midrst_data",    64'({fifo_data_in_2, fifo_data_in}), 64'(0));
        chk("midrst_wv",      64'({window_valid_1, window_valid_2, done}), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(n_done - d0), 64'(0));
        run_pass("after_rst", 0, 0);

        run_pass("start_busy", 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
